// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise logic unit (AND/ORR/EOR/BIC) feeding a 2-entry
// in-order result buffer with valid/ready handshakes on both sides.
// The head entry is kept in the y/flags registers themselves, so the outputs
// are registered and simply hold their last value when the buffer empties.
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       flags,
    output logic [15:0]      done_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Bitwise operation selected by op; result is always exactly WIDTH bits.
    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] sel,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        case (sel)
            2'b00:   r = x & z;
            2'b01:   r = x | z;
            2'b10:   r = x ^ z;
            2'b11:   r = x & ~z;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Flags stored alongside each result: {N, Z}.
    function automatic logic [1:0] make_flags(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == {WIDTH{1'b0}})};
    endfunction

    state_t           state;
    state_t           next_state;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] new_y;
    logic [1:0]       new_flags;
    logic [WIDTH-1:0] second_y;
    logic [1:0]       second_flags;
    logic [WIDTH-1:0] y_next;
    logic [1:0]       flags_next;
    logic [WIDTH-1:0] second_y_next;
    logic [1:0]       second_flags_next;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign new_y     = logic_op(op, a, b);
    assign new_flags = make_flags(new_y);

    // Occupancy transitions; a FULL buffer never pushes because in_ready is low.
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (push) begin
                    next_state = ONE;
                end else begin
                    next_state = EMPTY;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    next_state = FULL;
                end else if (pop && !push) begin
                    next_state = EMPTY;
                end else begin
                    next_state = ONE;
                end
            end
            FULL: begin
                if (pop) begin
                    next_state = ONE;
                end else begin
                    next_state = FULL;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Buffer contents: head lives in y/flags, second entry behind it.
    always_comb begin
        y_next            = y;
        flags_next        = flags;
        second_y_next     = second_y;
        second_flags_next = second_flags;
        case (state)
            EMPTY: begin
                if (push) begin
                    y_next     = new_y;
                    flags_next = new_flags;
                end else begin
                    y_next     = y;
                    flags_next = flags;
                end
            end
            ONE: begin
                if (push && pop) begin
                    y_next     = new_y;
                    flags_next = new_flags;
                end else if (push) begin
                    second_y_next     = new_y;
                    second_flags_next = new_flags;
                end else begin
                    y_next     = y;
                    flags_next = flags;
                end
            end
            FULL: begin
                if (pop) begin
                    y_next     = second_y;
                    flags_next = second_flags;
                end else begin
                    y_next     = y;
                    flags_next = flags;
                end
            end
            default: begin
                y_next     = {WIDTH{1'b0}};
                flags_next = 2'b00;
            end
        endcase
    end

    // State, handshake outputs, buffer storage and the completion counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= EMPTY;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            y            <= {WIDTH{1'b0}};
            flags        <= 2'b00;
            second_y     <= {WIDTH{1'b0}};
            second_flags <= 2'b00;
            done_count   <= 16'd0;
        end else begin
            state        <= next_state;
            in_ready     <= (next_state != FULL);
            out_valid    <= (next_state != EMPTY);
            y            <= y_next;
            flags        <= flags_next;
            second_y     <= second_y_next;
            second_flags <= second_flags_next;
            if (pop) begin
                done_count <= done_count + 16'd1;
            end else begin
                done_count <= done_count;
            end
        end
    end

endmodule
